aes_round_engine: RTL

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_round_comb.sv | 38 +++
 rtl/aes_round_engine.sv | 97 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: AES block width, round-count constants, FSM state type, S-box and GF(2^8) helpers.
// Latency: n/a (compile-time constants and pure combinational functions).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES128_NR   = 10;
    localparam int AES192_NR   = 12;
    localparam int AES256_NR   = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_t;

    // Forward S-box, indexed by the input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one AES encryption round, SubBytes -> ShiftRows -> MixColumns (skipped when i_final) -> AddRoundKey.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: i_state (128b round input), i_round_key (128b), i_final (1 = last round, no MixColumns), o_state (128b result).
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] i_state,
    input  logic [AES_BLOCK_W-1:0] i_round_key,
    input  logic                   i_final,
    output logic [AES_BLOCK_W-1:0] o_state
);

    // Byte k sits at bits [127-8k -: 8]; it is row k%4, column k/4 of the state matrix.
    logic [7:0]             w_sb [16];
    logic [7:0]             w_sr [16];
    logic [7:0]             w_mc [16];
    logic [AES_BLOCK_W-1:0] w_pre_key;

    for (genvar k = 0; k < 16; k++) begin : g_byte
        assign w_sb[k] = sbox(i_state[AES_BLOCK_W-1-8*k -: 8]);
        // Row r rotates left by r columns: out[r][c] = in[r][(c+r)%4].
        assign w_sr[k] = w_sb[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
        assign w_pre_key[AES_BLOCK_W-1-8*k -: 8] = i_final ? w_sr[k] : w_mc[k];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_mc[4*c+r] = xtime(w_sr[4*c+r])
                               ^ gf_mul3(w_sr[4*c+((r+1)%4)])
                               ^ w_sr[4*c+((r+2)%4)]
                               ^ w_sr[4*c+((r+3)%4)];
        end
    end

    assign o_state = w_pre_key ^ i_round_key;

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryptor, one round per cycle, round keys fetched from an external schedule via key_idx/key_in.
// Latency: block accepted at edge T is presented (out_valid) after edge T+NR, sampled by the consumer at edge T+NR+1; period NR+2.
// Backpressure: holds ciphertext in DONE until out_ready; in_ready only in IDLE, in_valid while busy is ignored.
// Ports: clk/rst (sync active-high), in_valid/in_ready/in_block, key_idx/key_in, out_valid/out_ready/out_block, busy.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR        = AES128_NR,
    parameter int KEY_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_block,
    output logic [KEY_IDX_W-1:0]   key_idx,
    input  logic [AES_BLOCK_W-1:0] key_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_block,
    output logic                   busy
);

    if ((2 ** KEY_IDX_W) <= NR) begin : g_bad_key_idx_w
        $error("KEY_IDX_W too narrow for NR");
    end

    localparam logic [KEY_IDX_W-1:0] LP_LAST_RND = KEY_IDX_W'(NR);

    aes_state_t             r_state;
    logic [KEY_IDX_W-1:0]   r_rnd;
    logic [AES_BLOCK_W-1:0] r_data;
    logic                   r_out_valid;
    logic [AES_BLOCK_W-1:0] r_out_block;

    logic                   w_final;
    logic [AES_BLOCK_W-1:0] w_round_out;

    assign w_final = (r_rnd == LP_LAST_RND);

    aes_round_comb u_round (
        .i_state     (r_data),
        .i_round_key (key_in),
        .i_final     (w_final),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rnd       <= '0;
            r_data      <= '0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey with round key 0 (key_idx is 0 here).
                        r_data  <= in_block ^ key_in;
                        r_rnd   <= KEY_IDX_W'(1);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_data <= w_round_out;
                    if (w_final) begin
                        // rnd returns to 0 so key_idx reads 0 through DONE and the next IDLE.
                        r_rnd       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_block <= w_round_out;
                        r_state     <= ST_DONE;
                    end else begin
                        r_rnd <= r_rnd + KEY_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_block <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign key_idx   = r_rnd;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;

endmodule
